seg_scan_bcd: RTL and testbench
===============================

Name: seg_scan_bcd

Overview:
- Parametrised multi-digit seven-segment scan controller; next generation of the status display driver.
- Two source modes:
  - text mode: caller supplies packed 5-bit glyph codes, one per digit.
  - numeric mode: caller loads a binary value; a sequential double-dabble converter produces BCD for display.
- Adds per-digit blink, decimal points, leading-zero blanking and saturation flag.
- Sits between the top-level FSM/timer and the board's anode/segment pins.

Parameters:
- NUM_DIGITS, 4, digit count (legal 1..8).
- DATA_W, 32, binary input width; must be ≥ ceil(log2(10^NUM_DIGITS)).
- REFRESH_DIV, 200000, clk cycles per digit dwell (≥2).
- BLINK_DIV, 25000000, clk cycles per blink half-period (≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = text, 1 = numeric
- glyphs  in  5*NUM_DIGITS  text codes; digit i at [5i+4:5i], digit 0 rightmost
- bin_val  in  DATA_W  binary value for numeric mode
- bin_load  in  1  request conversion of bin_val
- lz_blank  in  1  blank leading zeros in numeric mode
- blink_mask  in  NUM_DIGITS  per-digit blink enable
- dp_mask  in  NUM_DIGITS  per-digit decimal point
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when a new BCD result is committed
- ovf  out  1  last committed value exceeded 10^NUM_DIGITS−1
- seg  out  8  active-high segments, bit7 = dp
- an  out  NUM_DIGITS  active-high one-hot digit enable

Behaviour:
- Reset (async, rst_n=0): seg=0, an=0, busy=0, done=0, ovf=0, BCD display register=0, scan index=0, refresh and blink counters=0, blink phase=0.
- Glyph table (code→seg):
  - 0x00–0x09 digits 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - 0x0A–0x0F A/b/C/d/E/F 77,7C,39,5E,79,71.
  - 0x10 P 73; 0x11 t 78; 0x12 L 38; 0x13 r 50; 0x14 T 78; 0x15 J 1E; 0x16 '-' 40; 0x17 blank 00.
  - All other codes 00.
  - Table bit7 is always 0.
- Scan:
  - refresh counter counts 0..REFRESH_DIV−1 and wraps.
  - On wrap, scan index increments; after NUM_DIGITS−1 it returns to 0.
  - seg/an are registered from the current scan index: one-cycle latency, no glitch between digits.
- Blink:
  - blink counter counts 0..BLINK_DIV−1; phase toggles on wrap.
  - When phase=1 and blink_mask[idx]=1, seg=0x00 (dp also off); an still driven.
- dp: seg[7]=dp_mask[idx] unless blanked by blink.
- Conversion handshake:
  - bin_load sampled high while busy=0 → bin_val captured; busy=1 on next edge.
  - Shift-add-3 runs one bit per cycle for DATA_W cycles.
  - On the commit cycle, BCD register and ovf are updated, done=1 for exactly one cycle, busy=0.
  - done rises DATA_W+1 cycles after the accepting edge.
  - bin_load while busy=1 is ignored (no queueing).
  - bin_load is accepted again on the cycle done is high.
- Saturation: if the captured value > 10^NUM_DIGITS−1, commit all digits = 9 and set ovf=1; otherwise ovf=0. ovf holds until the next commit.
- Numeric display:
  - Shows the committed BCD; the previous result is held during conversion.
  - With lz_blank=1, digits above the most significant nonzero digit show blank.
  - Digit 0 always displays, so value 0 shows "0".
  - Saturated output is never blanked.
- Mode switch takes effect on the next registered seg update. It does not abort or affect a conversion in progress.
- Reset mid-conversion: conversion is abandoned, no done pulse, and BCD returns to 0.

Test Plan:
- Scan order, REFRESH_DIV=4, NUM_DIGITS=4, text glyphs {0x0E,0x13,0x13,0x00} (digit3..0) → an sequence 0001,0010,0100,1000 every 4 cycles; seg 3F,50,50,79; wraps to 0001.
- Conversion, bin_val=1234, DATA_W=32, bin_load pulse → busy next cycle; done exactly 33 cycles after the accepting edge; digits 1,2,3,4; ovf=0; second bin_load during busy ignored.
- Saturation and blanking, bin_val=12345 → all digits 9 (6F), ovf=1. Then bin_val=7 with lz_blank=1 → digits 3..1 seg=00, digit0 seg=07, ovf=0. Then bin_val=0 → digit0 seg=3F.
- Blink/dp, BLINK_DIV=8, blink_mask=0010, dp_mask=0001 → digit1 seg alternates glyph/00 every 8 cycles; digit0 seg has bit7=1 always.
- Reset mid-operation: assert rst_n=0 at cycle 10 of a conversion → seg=0, an=0, busy=0 immediately (async); after release no done pulse and numeric display shows 0.
- Unmapped glyph 0x1F in text mode → seg=00 for that digit; other digits unaffected.

Source files
------------

// File: rtl/seg_scan_bcd.sv
// seg_scan_bcd: multiplexed seven-segment scan controller.
// Shows either caller-supplied glyph codes (text mode) or the BCD result of a
// sequential double-dabble conversion (numeric mode), with per-digit blink,
// decimal points, leading-zero blanking and a saturation flag.
//
// Conversion FSM states:
//   state  | meaning
//   IDLE   | waiting for bin_load; display holds the last committed result
//   SHIFT  | one shift-add-3 step per cycle, DATA_W steps in total
//   COMMIT | latch result (or all nines on overflow), pulse done
module seg_scan_bcd #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 200000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [5*NUM_DIGITS-1:0] glyphs,
  input  logic [DATA_W-1:0]       bin_val,
  input  logic                    bin_load,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW    = $clog2(REFRESH_DIV);
  localparam int BW    = $clog2(BLINK_DIV);
  localparam int CW    = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * NUM_DIGITS;

  // Largest value that fits in NUM_DIGITS decimal digits.
  function automatic logic [DATA_W-1:0] calc_max_val();
    logic [DATA_W-1:0] v;
    v = DATA_W'(1);
    for (int i = 0; i < NUM_DIGITS; i++) v = v * DATA_W'(10);
    return v - DATA_W'(1);
  endfunction

  localparam logic [DATA_W-1:0] MAX_VAL = calc_max_val();

  function automatic logic [6:0] glyph_seg(input logic [4:0] code);
    case (code)
      5'h00: glyph_seg = 7'h3F;
      5'h01: glyph_seg = 7'h06;
      5'h02: glyph_seg = 7'h5B;
      5'h03: glyph_seg = 7'h4F;
      5'h04: glyph_seg = 7'h66;
      5'h05: glyph_seg = 7'h6D;
      5'h06: glyph_seg = 7'h7D;
      5'h07: glyph_seg = 7'h07;
      5'h08: glyph_seg = 7'h7F;
      5'h09: glyph_seg = 7'h6F;
      5'h0A: glyph_seg = 7'h77;
      5'h0B: glyph_seg = 7'h7C;
      5'h0C: glyph_seg = 7'h39;
      5'h0D: glyph_seg = 7'h5E;
      5'h0E: glyph_seg = 7'h79;
      5'h0F: glyph_seg = 7'h71;
      5'h10: glyph_seg = 7'h73;
      5'h11: glyph_seg = 7'h78;
      5'h12: glyph_seg = 7'h38;
      5'h13: glyph_seg = 7'h50;
      5'h14: glyph_seg = 7'h78;
      5'h15: glyph_seg = 7'h1E;
      5'h16: glyph_seg = 7'h40;
      default: glyph_seg = 7'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

  conv_state_t         state;
  logic [RW-1:0]       refresh_cnt;
  logic [IW-1:0]       scan_idx;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic [DATA_W-1:0]   bin_sh;
  logic [BCD_W-1:0]    bcd_work;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_disp;
  logic [CW-1:0]       bit_cnt;
  logic                ovf_pend;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                zero_above;
  logic [3:0]          cur_digit;
  logic [4:0]          code;
  logic [7:0]          seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  // Digit dwell timer; advances the scan index on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      if (scan_idx == IW'(NUM_DIGITS - 1)) scan_idx <= '0;
      else                                 scan_idx <= scan_idx + IW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Blink half-period timer; toggles the blink phase on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Add 3 to every BCD digit that is 5 or more before the next shift.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM. Only NUM_DIGITS digits are kept: any value that needs
  // more is saturated to all nines, so the truncated work register is fine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
      bin_sh   <= '0;
      bcd_work <= '0;
      bcd_disp <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bin_load) begin
            bin_sh   <= bin_val;
            bcd_work <= '0;
            bit_cnt  <= CW'(DATA_W);
            ovf_pend <= (bin_val > MAX_VAL);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_work <= {bcd_adj[BCD_W-2:0], bin_sh[DATA_W-1]};
          bin_sh   <= bin_sh << 1;
          bit_cnt  <= bit_cnt - CW'(1);
          if (bit_cnt == CW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          bcd_disp <= ovf_pend ? {NUM_DIGITS{4'd9}} : bcd_work;
          ovf      <= ovf_pend;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Select the glyph for the digit currently being scanned.
  always_comb begin
    zero_above = 1'b1;
    lead_zero  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead_zero[i] = zero_above & (bcd_disp[4*i +: 4] == 4'd0);
      zero_above   = lead_zero[i];
    end
    cur_digit = bcd_disp[4*scan_idx +: 4];
    if (!mode)
      code = glyphs[5*scan_idx +: 5];
    else if (lz_blank && !ovf && lead_zero[scan_idx] && (scan_idx != '0))
      code = 5'h17;
    else
      code = {1'b0, cur_digit};
    if (blink_phase && blink_mask[scan_idx]) seg_next = 8'h00;
    else                                     seg_next = {dp_mask[scan_idx], glyph_seg(code)};
    an_next = NUM_DIGITS'(1) << scan_idx;
  end

  // Register the pin drivers so digit changes are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'h00;
      an  <= '0;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Testbench for seg_scan_bcd: directed and randomized steps checked against
// a decimal-arithmetic model of what each digit should display.
module tb_seg_scan_bcd;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RD = 4;
  localparam int BD = 8;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic [5*N-1:0] glyphs;
  logic [DW-1:0] bin_val;
  logic          bin_load;
  logic          lz_blank;
  logic [N-1:0]  blink_m;
  logic [N-1:0]  dp_m;
  logic          busy, done, ovf;
  logic [7:0]    seg;
  logic [N-1:0]  an;

  logic [4:0]    gcode [N];
  longint        model_val;
  int            tcnt;
  int            tests = 0;
  int            fails = 0;

  assign glyphs = {gcode[3], gcode[2], gcode[1], gcode[0]};

  seg_scan_bcd #(.NUM_DIGITS(N), .DATA_W(DW), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .glyphs(glyphs), .bin_val(bin_val),
    .bin_load(bin_load), .lz_blank(lz_blank), .blink_mask(blink_m), .dp_mask(dp_m),
    .busy(busy), .done(done), .ovf(ovf), .seg(seg), .an(an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges seen since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 0;
    else        tcnt <= tcnt + 1;
  end

  function automatic logic [6:0] glyph_ref(input logic [4:0] c);
    case (c)
      5'h00: return 7'h3F; 5'h01: return 7'h06; 5'h02: return 7'h5B; 5'h03: return 7'h4F;
      5'h04: return 7'h66; 5'h05: return 7'h6D; 5'h06: return 7'h7D; 5'h07: return 7'h07;
      5'h08: return 7'h7F; 5'h09: return 7'h6F; 5'h0A: return 7'h77; 5'h0B: return 7'h7C;
      5'h0C: return 7'h39; 5'h0D: return 7'h5E; 5'h0E: return 7'h79; 5'h0F: return 7'h71;
      5'h10: return 7'h73; 5'h11: return 7'h78; 5'h12: return 7'h38; 5'h13: return 7'h50;
      5'h14: return 7'h78; 5'h15: return 7'h1E; 5'h16: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic longint pow10(input int e);
    longint p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] exp_seg(input int idx, input int ph);
    logic [4:0] c;
    longint     p;
    int         d;
    if (ph == 1 && blink_m[idx]) return 8'h00;
    if (!mode) begin
      c = gcode[idx];
    end else begin
      p = pow10(idx);
      if (model_val > 9999) d = 9;
      else                  d = int'((model_val / p) % 10);
      if (lz_blank && model_val <= 9999 && idx > 0 && model_val < p) c = 5'h17;
      else                                                             c = 5'(d);
    end
    return {dp_m[idx], glyph_ref(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and compare the pin drivers with the model.
  task automatic step_check();
    int idx, ph;
    @(negedge clk);
    if (tcnt == 0) begin
      chk("an_before_scan", 32'(an), 0);
      chk("seg_before_scan", 32'(seg), 0);
    end else begin
      idx = ((tcnt - 1) / RD) % N;
      ph  = ((tcnt - 1) / BD) % 2;
      chk("an_scan", 32'(an), 32'(1) << idx);
      chk("seg_scan", 32'(seg), 32'(exp_seg(idx, ph)));
    end
  endtask

  task automatic start_conv(input longint v);
    bin_val  = 32'(v);
    bin_load = 1'b1;
    step_check();
    bin_load = 1'b0;
    chk("busy_after_accept", 32'(busy), 1);
  endtask

  task automatic wait_done(input longint v, input bit inject);
    int found = 0;
    for (int k = 1; k <= 40 && found == 0; k++) begin
      step_check();
      if (done === 1'b1) found = k;
      else               chk("busy_during_conv", 32'(busy), 1);
      if (inject && k == 5) begin bin_val = 32'd777; bin_load = 1'b1; end
      if (inject && k == 6) bin_load = 1'b0;
    end
    chk("done_latency", 32'(found), 33);
    chk("busy_at_done", 32'(busy), 0);
    chk("ovf_at_done", 32'(ovf), 32'(v > 9999));
    model_val = v;
  endtask

  initial begin
    longint v;
    rst_n = 1'b0; mode = 1'b0; bin_val = '0; bin_load = 1'b0;
    lz_blank = 1'b0; blink_m = '0; dp_m = '0; model_val = 0;
    gcode[3] = 5'h0E; gcode[2] = 5'h13; gcode[1] = 5'h13; gcode[0] = 5'h00;

    #23;
    chk("rst_seg", 32'(seg), 0);
    chk("rst_an", 32'(an), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    @(negedge clk) rst_n = 1'b1;

    // Text scan order "Err0".
    repeat (40) step_check();

    // Unmapped glyph on one digit.
    gcode[2] = 5'h1F;
    repeat (20) step_check();
    gcode[2] = 5'h13;

    // Numeric mode before any conversion shows 0000.
    mode = 1'b1;
    repeat (8) step_check();

    // 1234 with an ignored load while busy.
    start_conv(1234);
    wait_done(1234, 1'b1);
    step_check();
    chk("done_one_cycle", 32'(done), 0);
    repeat (16) step_check();

    // Saturation, then blanking of small values.
    start_conv(12345);
    wait_done(12345, 1'b0);
    repeat (16) step_check();
    lz_blank = 1'b1;
    start_conv(7);
    wait_done(7, 1'b0);
    repeat (16) step_check();
    start_conv(0);
    wait_done(0, 1'b0);
    repeat (16) step_check();

    // Load accepted on the cycle done is high.
    start_conv(42);
    wait_done(42, 1'b0);
    start_conv(9000);
    wait_done(9000, 1'b0);
    step_check();
    chk("done_after_chain", 32'(done), 0);

    // Random numeric values, including overflowing ones.
    repeat (6) begin
      lz_blank = 1'($urandom_range(0, 1));
      dp_m     = 4'($urandom);
      if ($urandom_range(0, 3) == 0) v = longint'($urandom);
      else                           v = longint'($urandom_range(0, 9999));
      start_conv(v);
      wait_done(v, 1'b0);
      repeat (12) step_check();
    end

    // Blink and decimal points.
    mode = 1'b0;
    gcode[3] = 5'h0E; gcode[2] = 5'h13; gcode[1] = 5'h13; gcode[0] = 5'h00;
    blink_m = 4'b0010; dp_m = 4'b0001;
    repeat (48) step_check();
    mode = 1'b1;
    repeat (24) step_check();

    // Random text glyphs and masks.
    mode = 1'b0;
    repeat (4) begin
      for (int i = 0; i < N; i++) gcode[i] = 5'($urandom_range(0, 31));
      blink_m = 4'($urandom);
      dp_m    = 4'($urandom);
      repeat (32) step_check();
    end

    // Reset in the middle of a conversion.
    blink_m = '0; dp_m = '0; mode = 1'b1; lz_blank = 1'b1;
    start_conv(5555);
    repeat (9) step_check();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", 32'(seg), 0);
    chk("midrst_an", 32'(an), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    model_val = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (50) begin
      step_check();
      chk("no_done_after_rst", 32'(done), 0);
    end
    chk("busy_after_rst", 32'(busy), 0);
    chk("ovf_after_rst", 32'(ovf), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
